// File: rtl/am_argmax_tracker_if.sv
// Handshake bundle between the similarity accumulator and the argmax tracker:
// per-class similarity stream in, registered prediction result out.
interface am_argmax_tracker_if #(
  parameter int NUM_CLASSES = 26,
  parameter int SIM_W       = 13
);
  localparam int CLASS_W = $clog2(NUM_CLASSES);

  logic               start;
  logic               sim_valid;
  logic [SIM_W-1:0]   sim_value;
  logic               busy;
  logic               pred_valid;
  logic [CLASS_W-1:0] pred_class;
  logic [SIM_W-1:0]   pred_sim;
  logic [SIM_W-1:0]   pred_margin;
  logic               seq_error;

  modport master (
    output start, sim_valid, sim_value,
    input  busy, pred_valid, pred_class, pred_sim, pred_margin, seq_error
  );

  modport slave (
    input  start, sim_valid, sim_value,
    output busy, pred_valid, pred_class, pred_sim, pred_margin, seq_error
  );
endinterface

// File: rtl/am_argmax_tracker.sv
// Tracks best / second-best similarity over a class-ordered stream and emits a
// one-cycle registered prediction (class, similarity, margin) after the last class.
module am_argmax_tracker #(
  parameter int NUM_CLASSES = 26,
  parameter int SIM_W       = 13
) (
  input  logic                clk,
  input  logic                nrst,
  am_argmax_tracker_if.slave  bus
);
  localparam int CLASS_W = $clog2(NUM_CLASSES);
  localparam logic [CLASS_W-1:0] LAST_CLS = CLASS_W'(NUM_CLASSES - 1);

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e             state_q, state_d;
  logic [CLASS_W-1:0] cls_cnt_q, cls_cnt_d;
  logic [SIM_W-1:0]   best_val_q, best_val_d;
  logic [CLASS_W-1:0] best_idx_q, best_idx_d;
  logic [SIM_W-1:0]   second_val_q, second_val_d;
  logic               seq_error_q, seq_error_d;
  logic               pred_valid_q, pred_valid_d;
  logic [CLASS_W-1:0] pred_class_q, pred_class_d;
  logic [SIM_W-1:0]   pred_sim_q, pred_sim_d;
  logic [SIM_W-1:0]   pred_margin_q, pred_margin_d;

  // Tracker values after absorbing the current sample; shared by the
  // register update and the final-result load so the last class is included.
  logic               take_best;
  logic [SIM_W-1:0]   nb_val, ns_val;
  logic [CLASS_W-1:0] nb_idx;

  always_comb begin
    take_best = (cls_cnt_q == '0) || (bus.sim_value > best_val_q);
    nb_val    = best_val_q;
    nb_idx    = best_idx_q;
    ns_val    = second_val_q;
    if (take_best) begin
      nb_val = bus.sim_value;
      nb_idx = cls_cnt_q;
      ns_val = (cls_cnt_q == '0) ? '0 : best_val_q;
    end else if (bus.sim_value > second_val_q) begin
      ns_val = bus.sim_value;
    end
  end

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d       = state_q;
    cls_cnt_d     = cls_cnt_q;
    best_val_d    = best_val_q;
    best_idx_d    = best_idx_q;
    second_val_d  = second_val_q;
    seq_error_d   = seq_error_q;
    pred_valid_d  = 1'b0;
    pred_class_d  = pred_class_q;
    pred_sim_d    = pred_sim_q;
    pred_margin_d = pred_margin_q;

    if (bus.start) begin
      // start wins over a coincident sample, which is dropped and flagged.
      state_d      = COLLECT;
      cls_cnt_d    = '0;
      best_val_d   = '0;
      best_idx_d   = '0;
      second_val_d = '0;
      seq_error_d  = bus.sim_valid;
    end else if (bus.sim_valid) begin
      if (state_q == IDLE) begin
        seq_error_d = 1'b1;
      end else begin
        best_val_d   = nb_val;
        best_idx_d   = nb_idx;
        second_val_d = ns_val;
        if (cls_cnt_q == LAST_CLS) begin
          state_d       = IDLE;
          cls_cnt_d     = '0;
          pred_valid_d  = 1'b1;
          pred_class_d  = nb_idx;
          pred_sim_d    = nb_val;
          pred_margin_d = nb_val - ns_val;
        end else begin
          cls_cnt_d = cls_cnt_q + CLASS_W'(1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      cls_cnt_q     <= '0;
      best_val_q    <= '0;
      best_idx_q    <= '0;
      second_val_q  <= '0;
      seq_error_q   <= 1'b0;
      pred_valid_q  <= 1'b0;
      pred_class_q  <= '0;
      pred_sim_q    <= '0;
      pred_margin_q <= '0;
    end else begin
      state_q       <= state_d;
      cls_cnt_q     <= cls_cnt_d;
      best_val_q    <= best_val_d;
      best_idx_q    <= best_idx_d;
      second_val_q  <= second_val_d;
      seq_error_q   <= seq_error_d;
      pred_valid_q  <= pred_valid_d;
      pred_class_q  <= pred_class_d;
      pred_sim_q    <= pred_sim_d;
      pred_margin_q <= pred_margin_d;
    end
  end

  assign bus.busy        = (state_q == COLLECT);
  assign bus.pred_valid  = pred_valid_q;
  assign bus.pred_class  = pred_class_q;
  assign bus.pred_sim    = pred_sim_q;
  assign bus.pred_margin = pred_margin_q;
  assign bus.seq_error   = seq_error_q;
endmodule

// File: tb/tb_am_argmax_tracker.sv
// Directed and randomized check of am_argmax_tracker against an array-based
// argmax / runner-up reference model.
module tb_am_argmax_tracker;
  localparam int NC    = 4;
  localparam int SIM_W = 13;

  logic clk;
  logic nrst;
  int   compared;
  int   mismatched;
  int   pv_count;
  int   exp_cls, exp_sim, exp_margin;

  am_argmax_tracker_if #(.NUM_CLASSES(NC), .SIM_W(SIM_W)) bus ();

  am_argmax_tracker #(.NUM_CLASSES(NC), .SIM_W(SIM_W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.pred_valid === 1'b1) pv_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Winner is the first index holding the maximum; runner-up is the maximum
  // of the remaining entries (equal to the winner on a tie).
  task automatic model(input int vals[$], output int idx, output int bv, output int margin);
    int sv;
    bv  = -1;
    idx = 0;
    for (int i = 0; i < vals.size(); i++)
      if (vals[i] > bv) begin bv = vals[i]; idx = i; end
    sv = 0;
    for (int i = 0; i < vals.size(); i++)
      if (i != idx && vals[i] > sv) sv = vals[i];
    margin = bv - sv;
  endtask

  task automatic feed(input string tag, input int vals[$], input int gap);
    for (int i = 0; i < vals.size(); i++) begin
      bus.sim_valid = 1'b1;
      bus.sim_value = SIM_W'(vals[i]);
      tick();
      bus.sim_valid = 1'b0;
      if (i < vals.size() - 1) begin
        check({tag, ".busy_mid"}, bus.busy, 1);
        check({tag, ".pv_mid"}, bus.pred_valid, 0);
        repeat (gap) tick();
      end
    end
  endtask

  task automatic check_result(input string tag, input int vals[$], input logic exp_err);
    model(vals, exp_cls, exp_sim, exp_margin);
    check({tag, ".pred_valid"}, bus.pred_valid, 1);
    check({tag, ".busy_end"}, bus.busy, 0);
    check({tag, ".pred_class"}, bus.pred_class, exp_cls);
    check({tag, ".pred_sim"}, bus.pred_sim, exp_sim);
    check({tag, ".pred_margin"}, bus.pred_margin, exp_margin);
    check({tag, ".seq_error"}, bus.seq_error, exp_err);
  endtask

  // Leaves time just after the result edge so a following call starts
  // back-to-back with pred_valid still high.
  task automatic run_inference(input string tag, input int vals[$], input int gap);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, ".busy_start"}, bus.busy, 1);
    check({tag, ".pv_start"}, bus.pred_valid, 0);
    check({tag, ".err_start"}, bus.seq_error, 0);
    feed(tag, vals, gap);
    check_result(tag, vals, 1'b0);
  endtask

  initial begin
    int q[$];
    int pv0;
    compared      = 0;
    mismatched    = 0;
    pv_count      = 0;
    nrst          = 1'b0;
    bus.start     = 1'b0;
    bus.sim_valid = 1'b0;
    bus.sim_value = '0;
    tick();
    tick();
    check("rst.busy", bus.busy, 0);
    check("rst.pred_valid", bus.pred_valid, 0);
    check("rst.pred_class", bus.pred_class, 0);
    check("rst.pred_sim", bus.pred_sim, 0);
    check("rst.pred_margin", bus.pred_margin, 0);
    check("rst.seq_error", bus.seq_error, 0);
    nrst = 1'b1;
    tick();

    q = '{100, 350, 200, 340};
    run_inference("basic", q, 0);
    check("basic.class_const", bus.pred_class, 1);
    check("basic.margin_const", bus.pred_margin, 10);

    q = '{500, 500, 12, 0};
    run_inference("tie_gap", q, 2);
    check("tie_gap.margin_const", bus.pred_margin, 0);
    tick();
    check("tie_gap.pv_one_cycle", bus.pred_valid, 0);

    q = '{0, 0, 0, 0};
    run_inference("zeros", q, 0);
    q = '{0, 0, 0, 8191};
    run_inference("max_last", q, 1);
    check("max_last.margin_const", bus.pred_margin, 8191);

    // Abort: two values, restart, four values -> exactly one result.
    tick();
    pv0 = pv_count;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    q = '{9, 8};
    feed("abort_pre", q, 0);
    q = '{1, 2, 3, 4};
    run_inference("abort", q, 0);
    tick();
    check("abort.pv_count", pv_count - pv0, 1);

    // sim_valid while idle: flagged, ignored, outputs held.
    pv0 = pv_count;
    bus.sim_valid = 1'b1;
    bus.sim_value = SIM_W'(7000);
    tick();
    bus.sim_valid = 1'b0;
    check("idle_sv.seq_error", bus.seq_error, 1);
    check("idle_sv.busy", bus.busy, 0);
    check("idle_sv.pred_class", bus.pred_class, exp_cls);
    check("idle_sv.pred_sim", bus.pred_sim, exp_sim);
    check("idle_sv.pred_margin", bus.pred_margin, exp_margin);
    tick();
    tick();
    check("idle_sv.pv_count", pv_count - pv0, 0);

    // A clean start clears the sticky error.
    q = '{30, 10, 20, 25};
    run_inference("err_clear", q, 0);

    // start with sim_valid: error set, sample dropped, count starts at 0.
    tick();
    bus.start     = 1'b1;
    bus.sim_valid = 1'b1;
    bus.sim_value = SIM_W'(8000);
    tick();
    bus.start     = 1'b0;
    bus.sim_valid = 1'b0;
    check("start_sv.seq_error", bus.seq_error, 1);
    check("start_sv.busy", bus.busy, 1);
    q = '{1, 2, 3, 4};
    feed("start_sv", q, 0);
    check_result("start_sv", q, 1'b1);
    check("start_sv.sim_const", bus.pred_sim, 4);

    // Asynchronous reset mid-collection.
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    q = '{4000, 5000};
    feed("rst_mid", q, 0);
    #2;
    nrst = 1'b0;
    #1;
    check("rst_mid.busy", bus.busy, 0);
    check("rst_mid.pred_valid", bus.pred_valid, 0);
    check("rst_mid.pred_class", bus.pred_class, 0);
    check("rst_mid.pred_sim", bus.pred_sim, 0);
    check("rst_mid.pred_margin", bus.pred_margin, 0);
    check("rst_mid.seq_error", bus.seq_error, 0);
    tick();
    nrst = 1'b1;
    tick();
    q = '{40, 60, 50, 10};
    run_inference("post_rst", q, 0);

    // Randomized back-to-back inferences with mixed value ranges and gaps.
    for (int n = 0; n < 40; n++) begin
      int mode;
      int gap;
      mode = $urandom_range(0, 2);
      gap  = $urandom_range(0, 2);
      q.delete();
      for (int i = 0; i < NC; i++) begin
        case (mode)
          0:       q.push_back($urandom_range(0, 8191));
          1:       q.push_back($urandom_range(0, 3));
          default: q.push_back($urandom_range(0, 1) * 8191);
        endcase
      end
      run_inference($sformatf("rand%0d", n), q, gap);
    end
    tick();
    check("final.pv_low", bus.pred_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
